sdm_modulator: RTL
==================

SDM_MODULATOR -- requirements
Module: sdm_modulator

Interface
REQ-001 SHALL have parameter I2_LIMIT, default 1048576 (2^20), |i2| threshold for the instability monitor.
REQ-002 SHALL have parameter RECOV_LEN, default 64, consecutive over-limit cycles that trigger recovery.
REQ-003 SHALL have parameter FLUSH_LEN, default 16, cycles spent in FLUSH.
REQ-004 SHALL have parameter DITHER_EN, default 1, which enables the LFSR dither.
REQ-005 clk  input  1  3.2 MHz master clock, the same clock as the interpolation chain output.
REQ-006 rst_n  input  1  Reset, asynchronous and active-low; one clock domain only.
REQ-007 en  input  1  Advance modulator state; when low, all state holds.
REQ-008 data_in  input  16 signed  3.2 MHz interpolated sample from the interpolation chain.
REQ-009 clr_flags  input  1  Synchronous clear of the sticky flags.
REQ-010 bit_out  output  1  1-bit delta-sigma stream to the DAC/PWM driver.
REQ-011 clip_flag  output  1  Sticky flag: an input clamp occurred.
REQ-012 sat_flag  output  1  Sticky flag: integrator saturation occurred.
REQ-013 recover_pulse  output  1  One-cycle pulse on entering FLUSH.

Function
REQ-014 SHALL implement a 2nd-order single-bit modulator with all arithmetic in 24-bit signed.
REQ-015 SHALL clamp the input: x = data_in clamped to [-16384, +16383]; any clamp sets clip_flag.
REQ-016 SHALL use feedback fb = +32768 when bit_out is 1, -32768 when bit_out is 0, taken from the registered bit_out.
REQ-017 SHALL update the integrators in RUN with en high as follows: i1 <= sat(i1 + x - fb); i2 <= sat(i2 + i1_next - fb), where sat() limits to ±(2^23-1) and any limiting sets sat_flag.
REQ-018 SHALL quantise in RUN as bit_out <= ((i2_next + d) >= 0), where d = -lfsr[0] when DITHER_EN=1, else 0.
REQ-019 SHALL use a 15-bit Fibonacci LFSR for dither: polynomial x^15+x^14+1, seed 15'h0001, advancing only when en is high.
REQ-020 SHALL have a latency of 1 cycle: data_in sampled at edge k contributes to bit_out valid after edge k.
REQ-021 SHALL implement a state machine with states RUN and FLUSH.
REQ-022 SHALL, in RUN, increment ovr_cnt on each en cycle where |i2_next| > I2_LIMIT and clear it otherwise.
REQ-023 SHALL leave RUN for FLUSH when ovr_cnt reaches RECOV_LEN-1 and the current cycle is also over limit, asserting recover_pulse for exactly that cycle.
REQ-024 SHALL, in FLUSH, hold i1 = i2 = 0, toggle bit_out every en cycle starting at 1, and count FLUSH_LEN en cycles before returning to RUN with ovr_cnt = 0.
REQ-025 SHALL, when en is low in either state, freeze all registers, counters, LFSR and bit_out; flags still honour clr_flags.
REQ-026 SHALL give set priority over clear when clr_flags coincides with a new clip or saturation event, so the flag reads 1 the next cycle.
REQ-027 SHALL update clip_flag and sat_flag only on en cycles.

Reset
REQ-028 SHALL, on rst_n low, asynchronously set i1 = i2 = 0, bit_out = 0, clip_flag = sat_flag = recover_pulse = 0, ovr_cnt = flush counter = 0, LFSR = 15'h0001 and state = RUN.
REQ-029 SHALL, on reset asserted mid-FLUSH, come up in RUN with no pending recover_pulse.

Structure
REQ-030 SHALL place the 24-bit width constant, the ±32768 feedback level, the clamp limits, the LFSR seed/taps and the RUN/FLUSH state encoding in a shared package (sdm_pkg).
REQ-031 SHALL contain one sub-module: sdm_lfsr15 (15-bit LFSR with enable).
REQ-032 SHALL keep the saturating adders inline.

Verification
REQ-033 Reset then data_in=0, en=1, DITHER_EN=0 for 1024 cycles -> ones count 512±4, no flags set.
REQ-034 data_in=+8192 for 4096 cycles -> ones density 0.625±0.005 (2560±20).
REQ-035 data_in=+30000 for 1 cycle, then clr_flags asserted on the same cycle as a second clip -> clip_flag=1 after both events; clr_flags alone on a later cycle -> clip_flag=0.
REQ-036 I2_LIMIT=40000, RECOV_LEN=8, data_in=+16383 -> recover_pulse after 8 consecutive over-limit cycles, then 16 cycles of alternating 1,0,..., then RUN with i1=i2=0.
REQ-037 en toggled low for 10 cycles mid-stream -> bit_out and LFSR unchanged across the gap, and the stream after resume matches an ungated reference model.
REQ-038 rst_n pulsed low mid-FLUSH -> all outputs 0 immediately, state RUN after release.

Source files
------------

// File: rtl/sdm_pkg.sv
// Shared constants and types for the 2nd-order single-bit delta-sigma modulator.
package sdm_pkg;

  localparam int unsigned SDM_W = 24;

  localparam logic signed [SDM_W-1:0] FB_LEVEL = 24'sd32768;
  localparam logic signed [SDM_W-1:0] SAT_MAX  = 24'sd8388607;
  localparam logic signed [SDM_W-1:0] SAT_MIN  = -24'sd8388607;

  localparam logic signed [15:0] CLAMP_HI = 16'sd16383;
  localparam logic signed [15:0] CLAMP_LO = -16'sd16384;

  // Fibonacci x^15 + x^14 + 1: feedback is the XOR of bits 14 and 13.
  localparam logic [14:0] LFSR_SEED = 15'h0001;
  localparam logic [14:0] LFSR_TAPS = 15'h6000;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } sdm_state_e;

endpackage

// File: rtl/sdm_lfsr15.sv
// 15-bit Fibonacci LFSR with enable; only the low bit leaves the block as dither.
module sdm_lfsr15
  import sdm_pkg::*;
(
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic lsb_o
);

  logic [14:0] lfsr_q;
  logic [14:0] lfsr_d;
  logic        fb_s;

  always_comb begin
    fb_s = ^(lfsr_q & LFSR_TAPS);
    if (en_i) begin
      lfsr_d = {lfsr_q[13:0], fb_s};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign lsb_o = lfsr_q[0];

endmodule

// File: rtl/sdm_modulator.sv
// 2nd-order single-bit delta-sigma modulator with clamp, saturating integrators,
// optional LFSR dither and a RUN/FLUSH recovery state machine.
module sdm_modulator
  import sdm_pkg::*;
#(
  parameter int I2_LIMIT  = 1048576,
  parameter int RECOV_LEN = 64,
  parameter int FLUSH_LEN = 16,
  parameter int DITHER_EN = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic signed [15:0] data_in,
  input  logic               clr_flags,
  output logic               bit_out,
  output logic               clip_flag,
  output logic               sat_flag,
  output logic               recover_pulse
);

  sdm_state_e state_q, state_d;

  logic signed [SDM_W-1:0] i1_q, i1_d;
  logic signed [SDM_W-1:0] i2_q, i2_d;
  logic                    bit_q, bit_d;
  logic                    clip_q, clip_d;
  logic                    sat_q, sat_d;
  logic                    rp_q, rp_d;
  logic [15:0]             ovr_q, ovr_d;
  logic [15:0]             fcnt_q, fcnt_d;

  logic                    lfsr_lsb_s;
  logic signed [SDM_W-1:0] x_s;
  logic signed [SDM_W-1:0] fb_s;
  logic signed [25:0]      sum1_s, sum2_s;
  logic signed [SDM_W-1:0] i1_n_s, i2_n_s;
  logic                    clip_evt_s, sat1_s, sat2_s;
  logic [SDM_W-1:0]        mag_s;
  logic                    over_s;
  logic                    dith_s;
  logic [24:0]             qsum_s;
  logic                    q_bit_s;
  logic                    enter_s;
  logic                    flush_done_s;

  sdm_lfsr15 u_lfsr (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .en_i   (en),
    .lsb_o  (lfsr_lsb_s)
  );

  // Datapath: clamp, two saturating integrators, instability monitor, quantiser.
  always_comb begin
    if (data_in > CLAMP_HI) begin
      x_s        = 24'(CLAMP_HI);
      clip_evt_s = 1'b1;
    end else if (data_in < CLAMP_LO) begin
      x_s        = 24'(CLAMP_LO);
      clip_evt_s = 1'b1;
    end else begin
      x_s        = 24'(data_in);
      clip_evt_s = 1'b0;
    end

    fb_s   = bit_q ? FB_LEVEL : -FB_LEVEL;
    sum1_s = 26'(i1_q) + 26'(x_s) - 26'(fb_s);
    if (sum1_s > 26'(SAT_MAX)) begin
      i1_n_s = SAT_MAX;
      sat1_s = 1'b1;
    end else if (sum1_s < 26'(SAT_MIN)) begin
      i1_n_s = SAT_MIN;
      sat1_s = 1'b1;
    end else begin
      i1_n_s = sum1_s[23:0];
      sat1_s = 1'b0;
    end

    sum2_s = 26'(i2_q) + 26'(i1_n_s) - 26'(fb_s);
    if (sum2_s > 26'(SAT_MAX)) begin
      i2_n_s = SAT_MAX;
      sat2_s = 1'b1;
    end else if (sum2_s < 26'(SAT_MIN)) begin
      i2_n_s = SAT_MIN;
      sat2_s = 1'b1;
    end else begin
      i2_n_s = sum2_s[23:0];
      sat2_s = 1'b0;
    end

    // Saturation is symmetric, so negating i2 can never overflow.
    mag_s   = i2_n_s[23] ? 24'(-i2_n_s) : 24'(i2_n_s);
    over_s  = ({8'd0, mag_s} > 32'(I2_LIMIT));
    dith_s  = (DITHER_EN != 0) ? lfsr_lsb_s : 1'b0;
    qsum_s  = 25'(i2_n_s) - {24'd0, dith_s};
    q_bit_s = ~qsum_s[24];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    enter_s      = 1'b0;
    flush_done_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (en && over_s && (ovr_q == 16'(RECOV_LEN - 1))) begin
          state_d = ST_FLUSH;
          enter_s = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        if (en && (fcnt_q == 16'(FLUSH_LEN - 1))) begin
          state_d      = ST_RUN;
          flush_done_s = 1'b1;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Entry into FLUSH parks bit_out at 0 so the flush toggling starts with a 1.
  always_comb begin
    i1_d   = i1_q;
    i2_d   = i2_q;
    bit_d  = bit_q;
    ovr_d  = ovr_q;
    fcnt_d = fcnt_q;
    rp_d   = enter_s;
    if (en) begin
      case (state_q)
        ST_RUN: begin
          if (enter_s) begin
            i1_d   = '0;
            i2_d   = '0;
            bit_d  = 1'b0;
            ovr_d  = '0;
            fcnt_d = '0;
          end else begin
            i1_d  = i1_n_s;
            i2_d  = i2_n_s;
            bit_d = q_bit_s;
            ovr_d = over_s ? (ovr_q + 16'd1) : 16'd0;
          end
        end
        ST_FLUSH: begin
          i1_d   = '0;
          i2_d   = '0;
          bit_d  = ~fcnt_q[0];
          ovr_d  = '0;
          fcnt_d = flush_done_s ? 16'd0 : (fcnt_q + 16'd1);
        end
        default: begin
          i1_d   = '0;
          i2_d   = '0;
          bit_d  = 1'b0;
          ovr_d  = '0;
          fcnt_d = '0;
        end
      endcase
    end else begin
      rp_d = 1'b0;
    end

    // A new event wins over a coincident clear.
    if (en && clip_evt_s) begin
      clip_d = 1'b1;
    end else if (clr_flags) begin
      clip_d = 1'b0;
    end else begin
      clip_d = clip_q;
    end
    if (en && (state_q == ST_RUN) && (sat1_s || sat2_s)) begin
      sat_d = 1'b1;
    end else if (clr_flags) begin
      sat_d = 1'b0;
    end else begin
      sat_d = sat_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i1_q   <= '0;
      i2_q   <= '0;
      bit_q  <= 1'b0;
      clip_q <= 1'b0;
      sat_q  <= 1'b0;
      rp_q   <= 1'b0;
      ovr_q  <= '0;
      fcnt_q <= '0;
    end else begin
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      bit_q  <= bit_d;
      clip_q <= clip_d;
      sat_q  <= sat_d;
      rp_q   <= rp_d;
      ovr_q  <= ovr_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign bit_out       = bit_q;
  assign clip_flag     = clip_q;
  assign sat_flag      = sat_q;
  assign recover_pulse = rp_q;

endmodule
